// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port round-robin arbiter in front of a single-ported synchronous SRAM.
// Each requester issues one access (read or byte-masked write) at a time and
// gets exactly one response back, for writes as well as reads. Writes return
// the previous word contents because the SRAM is read-first. The arbiter keeps
// at most one response outstanding. A new access is issued in the same cycle
// that the pending response is consumed, so a stream sustains one access per
// clock.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready     request handshake for requester N (N = 0, 1)
//   reqN_addr                   byte address
//   reqN_wdata, reqN_wstrb      write data and byte strobes (all-zero = read)
//   rspN_valid / rspN_ready     response handshake for requester N
//   rspN_rdata                  response data (0 unless port N owns the response)
//   sram_en, sram_we            SRAM access enable and byte write enables
//   sram_addr, sram_din         SRAM address and write data
//   sram_dout                   SRAM read data (registered, 1-cycle latency,
//                               holds its value while sram_en = 0)
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int LEN_ADDR = 32,
  parameter int LEN_DATA = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  // requester 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [LEN_ADDR-1:0]   req0_addr,
  input  logic [LEN_DATA-1:0]   req0_wdata,
  input  logic [LEN_DATA/8-1:0] req0_wstrb,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [LEN_DATA-1:0]   rsp0_rdata,

  // requester 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [LEN_ADDR-1:0]   req1_addr,
  input  logic [LEN_DATA-1:0]   req1_wdata,
  input  logic [LEN_DATA/8-1:0] req1_wstrb,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [LEN_DATA-1:0]   rsp1_rdata,

  // SRAM
  output logic [LEN_ADDR-1:0]   sram_addr,
  output logic [LEN_DATA-1:0]   sram_din,
  output logic                  sram_en,
  output logic [LEN_DATA/8-1:0] sram_we,
  input  logic [LEN_DATA-1:0]   sram_dout
);

  localparam int LEN_STRB = LEN_DATA / 8;

  // IDLE: no response outstanding. PEND: one response owned by own_q.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   own_q,   own_d;    // requester that owns the pending response
  logic   prio_q,  prio_d;   // requester that wins the next tie

  logic   grant;             // requester selected this cycle (0 or 1)
  logic   any_valid;
  logic   own_rsp_ready;
  logic   rsp_handshake;     // pending response consumed this cycle
  logic   can_issue;
  logic   accept;            // an access is issued to the SRAM this cycle

  // ---------------------------------------------------------------------------
  // Arbitration. The grant looks only at the valids and the priority pointer,
  // never at the readies, so there is no combinational loop through a
  // requester whose valid depends on its ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign any_valid     = req0_valid | req1_valid;
  assign own_rsp_ready = own_q ? rsp1_ready : rsp0_ready;
  assign rsp_handshake = (state_q == ST_PEND) && own_rsp_ready;

  // The single response slot is free when nothing is pending or when the
  // pending response leaves in this very cycle.
  assign can_issue = (state_q == ST_IDLE) || rsp_handshake;
  assign accept    = can_issue && any_valid;

  // ---------------------------------------------------------------------------
  // Request-side outputs and the SRAM port. During reset the flops are already
  // cleared, but the path from reqN_valid to sram_en is combinational. It is
  // therefore masked with rst_n so that no access or handshake leaks out while
  // reset is held. rst_n only gates outputs here and never feeds a flop D input.
  // ---------------------------------------------------------------------------
  assign req0_ready = rst_n && can_issue && !grant;
  assign req1_ready = rst_n && can_issue &&  grant;

  assign sram_en   = rst_n && accept;
  assign sram_addr = grant ? req1_addr  : req0_addr;
  assign sram_din  = grant ? req1_wdata : req0_wdata;

  always_comb begin
    sram_we = '0;
    if (sram_en) begin
      sram_we = grant ? req1_wstrb : req0_wstrb;
    end
  end

  // ---------------------------------------------------------------------------
  // Response side. sram_dout is stable while a response waits, because no new
  // access can be issued until the pending response is taken.
  // ---------------------------------------------------------------------------
  assign rsp0_valid = (state_q == ST_PEND) && !own_q;
  assign rsp1_valid = (state_q == ST_PEND) &&  own_q;
  assign rsp0_rdata = rsp0_valid ? sram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? sram_dout : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    own_d   = own_q;
    prio_d  = prio_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PEND;
          own_d   = grant;
        end
      end
      ST_PEND: begin
        if (accept) begin
          // The old response leaves and the new one takes its slot.
          state_d = ST_PEND;
          own_d   = grant;
        end else if (rsp_handshake) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The requester that just lost (or did not ask) wins the next tie. This
    // alternates grants under continuous contention.
    if (accept) begin
      prio_d = ~grant;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so that all registers update together
      // from values sampled before the edge.
      state_q <= state_d;
      own_q   <= own_d;
      prio_q  <= prio_d;
    end
  end

  // Unused-width guard: the strobe width is tied to the data width.
  if (LEN_STRB * 8 != LEN_DATA) begin : g_bad_width
    $error("sram_arbiter: LEN_DATA must be a multiple of 8");
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter. It contains:
//   - a behavioural SRAM (read-first, 1-cycle latency, holds dout when idle)
//   - a transaction-level reference: one response slot held as a queue of
//     {port, data}, a round-robin "next winner" bit and a word-level memory
//   - a negedge compare process that checks every DUT output on every cycle
//   - literal expectations at the interesting points of the directed sequence
// Unwritten memory words read as 0xA000_0000 + word index.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_addr,  req0_wdata;
  logic [3:0]  req0_wstrb;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_addr,  req1_wdata;
  logic [3:0]  req1_wstrb;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_rdata;
  logic [31:0] sram_addr, sram_din, sram_dout;
  logic        sram_en;
  logic [3:0]  sram_we;

  int tests = 0;
  int fails = 0;

  sram_arbiter #(.LEN_ADDR(32), .LEN_DATA(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_wstrb (req0_wstrb),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_wstrb (req1_wstrb),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_rdata (rsp1_rdata),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_dout  (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return 32'hA000_0000 + 32'(w);
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural SRAM driven by the DUT
  // ---------------------------------------------------------------------------
  logic [31:0] env_mem [int];

  always @(posedge clk) begin : env_sram
    logic [31:0] word;
    int          w;
    if (sram_en) begin
      w    = int'(sram_addr >> 2);
      word = env_mem.exists(w) ? env_mem[w] : init_word(w);
      sram_dout <= word;
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) word[8*b +: 8] = sram_din[8*b +: 8];
      end
      env_mem[w] = word;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          port;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rsp_q[$];       // responses owed, at most one
  bit          m_next;         // who wins a tie next
  logic [31:0] model_mem [int];

  function automatic bit m_winner();
    if (req0_valid && req1_valid) return m_next;
    return req1_valid;
  endfunction

  function automatic bit m_slot_free();
    if (rsp_q.size() == 0) return 1'b1;
    return rsp_q[0].port ? rsp1_ready : rsp0_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_update
    rsp_t        r;
    bit          free;
    bit          w;
    int          idx;
    logic [31:0] word;
    logic [31:0] wd;
    logic [3:0]  st;
    if (!rst_n) begin
      rsp_q.delete();
      m_next = 1'b0;
    end else begin
      free = m_slot_free();
      w    = m_winner();
      if (rsp_q.size() != 0 && free) void'(rsp_q.pop_front());
      if (free && (req0_valid || req1_valid)) begin
        idx  = int'((w ? req1_addr : req0_addr) >> 2);
        wd   = w ? req1_wdata : req0_wdata;
        st   = w ? req1_wstrb : req0_wstrb;
        word = model_mem.exists(idx) ? model_mem[idx] : init_word(idx);
        r.port = w;
        r.data = word;
        rsp_q.push_back(r);
        for (int b = 0; b < 4; b++) begin
          if (st[b]) word[8*b +: 8] = wd[8*b +: 8];
        end
        model_mem[idx] = word;
        m_next = !w;
      end
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin : compare
    bit free;
    bit w;
    bit en;
    bit has;
    if (!rst_n) begin
      check("rst req0_ready", req0_ready, 0);
      check("rst req1_ready", req1_ready, 0);
      check("rst sram_en",    sram_en,    0);
      check("rst sram_we",    sram_we,    0);
      check("rst rsp0_valid", rsp0_valid, 0);
      check("rst rsp1_valid", rsp1_valid, 0);
    end else begin
      free = m_slot_free();
      w    = m_winner();
      en   = free && (req0_valid || req1_valid);
      has  = rsp_q.size() != 0;
      check("cmp req0_ready", req0_ready, free && !w);
      check("cmp req1_ready", req1_ready, free &&  w);
      check("cmp sram_en",    sram_en,    en);
      check("cmp sram_we",    sram_we,    en ? (w ? req1_wstrb : req0_wstrb) : 4'h0);
      if (en) begin
        check("cmp sram_addr", sram_addr, w ? req1_addr  : req0_addr);
        check("cmp sram_din",  sram_din,  w ? req1_wdata : req0_wdata);
      end
      check("cmp rsp0_valid", rsp0_valid, has && !rsp_q[0].port);
      check("cmp rsp1_valid", rsp1_valid, has &&  rsp_q[0].port);
      check("cmp rsp0_rdata", rsp0_rdata, (has && !rsp_q[0].port) ? rsp_q[0].data : 32'h0);
      check("cmp rsp1_rdata", rsp1_rdata, (has &&  rsp_q[0].port) ? rsp_q[0].data : 32'h0);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req0_valid = v; req0_addr = a; req0_wdata = d; req0_wstrb = s;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req1_valid = v; req1_addr = a; req1_wdata = d; req1_wstrb = s;
  endtask

  initial begin
    rst_n = 1'b0;
    drive0(1'b1, 32'h0, 32'h0, 4'h0);  // valid during reset must not reach the SRAM
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #2;
    check("reset sram_en",    sram_en,    0);
    check("reset sram_we",    sram_we,    0);
    check("reset rsp0_valid", rsp0_valid, 0);
    check("reset req0_ready", req0_ready, 0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b0;
    tick();

    // Read after write on port 0
    drive0(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("raw wr sram_en", sram_en, 1);
    check("raw wr sram_we", sram_we, 4'hF);
    tick();
    drive0(1'b1, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("raw wr rsp old data", rsp0_rdata, 32'hA000_0004);
    check("raw rd req0_ready",   req0_ready, 1);
    tick();
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("raw rd rsp0_valid", rsp0_valid, 1);
    check("raw rd rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
    tick();

    // Backpressure on port 0 with port 1 waiting
    drive0(1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b1, 32'h0, 32'h0, 4'h0);
    rsp0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp rsp0_valid", rsp0_valid, 1);
      check("bp rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
      check("bp req0_ready", req0_ready, 0);
      check("bp req1_ready", req1_ready, 0);
      check("bp sram_en",    sram_en,    0);
      tick();
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp release sram_en",    sram_en,    1);
    check("bp release req1_ready", req1_ready, 1);
    tick();
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("bp rsp1_rdata", rsp1_rdata, 32'hA000_0000);
    check("bp rsp0_rdata", rsp0_rdata, 32'h0);
    tick();

    // Byte strobe merge
    drive0(1'b1, 32'h20, 32'h1122_3344, 4'hF);
    tick();
    drive0(1'b1, 32'h20, 32'h0000_AA00, 4'h2);
    tick();
    drive0(1'b1, 32'h20, 32'h0, 4'h0);
    tick();
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("strb rsp0_rdata", rsp0_rdata, 32'h1122_AA44);
    tick();

    // Back-to-back reads on port 1
    drive1(1'b1, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) req1_addr = 32'((i + 1) * 4);
      else       req1_valid = 1'b0;
      @(negedge clk);
      check("b2b rsp1_valid", rsp1_valid, 1);
      check("b2b rsp1_rdata", rsp1_rdata, 32'hA000_0000 + 32'(i));
    end
    tick();

    // Contention right after reset
    rst_n = 1'b0;
    #1;
    check("rst2 rsp valid", {rsp0_valid, rsp1_valid}, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    drive0(1'b1, 32'h30, 32'h0, 4'h0);
    drive1(1'b1, 32'h34, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr req0_ready", req0_ready, (k % 2) == 0);
      check("rr req1_ready", req1_ready, (k % 2) == 1);
      if (k % 2 == 1) begin
        check("rr rsp0_rdata", rsp0_rdata, 32'hA000_000C);
        check("rr rsp1_valid", rsp1_valid, 0);
      end else if (k != 0) begin
        check("rr rsp1_rdata", rsp1_rdata, 32'hA000_000D);
        check("rr rsp0_valid", rsp0_valid, 0);
      end
      tick();
    end
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("rr last rsp1_valid", rsp1_valid, 1);
    check("rr last rsp0_valid", rsp0_valid, 0);

    // Reset while port 1 holds a response
    #2;
    rst_n = 1'b0;
    #1;
    check("async rsp1_valid", rsp1_valid, 0);
    drive0(1'b1, 32'h30, 32'h0, 4'h0);
    drive1(1'b1, 32'h34, 32'h0, 4'h0);
    #1;
    check("async sram_en", sram_en, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst req0_ready", req0_ready, 1);
    check("post rst req1_ready", req1_ready, 0);
    check("post rst rsp1_valid", rsp1_valid, 0);
    check("post rst rsp0_valid", rsp0_valid, 0);
    tick();
    drive0(1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("post rst rsp0 data",  rsp0_rdata, 32'hA000_000C);
    check("post rst no stale",   rsp1_valid, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
